// File: rtl/lvt_serial_host.sv
// Serial host: shifts a latched command frame out on d, strobes push, and
// optionally deserializes the q readback. Readback is enabled by LVT_HOST_READBACK_EN.
module lvt_serial_host #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 512,
    parameter int PORTS    = 32,
    parameter int HOLD_CYC = 4,
    parameter int RD_LAT   = 3,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [PORTS*AW-1:0]    cmd_addr,
    input  logic [PORTS*WIDTH-1:0] cmd_data,
    input  logic [PORTS-1:0]       cmd_en,
    output logic                   d,
    output logic                   push,
    input  logic                   q,
    output logic [PORTS*WIDTH-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   busy
);

    localparam int N     = PORTS * (AW + WIDTH + 1);
    localparam int RW    = PORTS * WIDTH;
    localparam int MAX_A = (N > HOLD_CYC) ? N : HOLD_CYC;
    localparam int MAXC  = (MAX_A > RD_LAT) ? MAX_A : RD_LAT;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] SHIFT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CW-1:0] WAIT_LAST  = CW'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [CW-1:0] CAP_LAST   = CW'(RW - 1);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_PUSH,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [N-1:0]    frame_reg;
    logic [N-1:0]    frame_in;
    logic            d_reg;
    logic            ready_en_reg;
    logic            accept;

    assign frame_in = {cmd_en, cmd_data, cmd_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ready_en_reg keeps cmd_ready low until the first edge after reset release
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        push       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = ready_en_reg;
                accept    = cmd_valid && ready_en_reg;
                if (accept) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_reg == SHIFT_LAST) begin
                    state_next = (HOLD_CYC == 0) ? ST_PUSH : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_PUSH;
                end
            end
            ST_PUSH: begin
                push = 1'b1;
`ifdef LVT_HOST_READBACK_EN
                state_next = (RD_LAT == 0) ? ST_CAPTURE : ST_WAIT;
`else
                state_next = ST_IDLE;
`endif
            end
            ST_WAIT: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (cnt_reg == CAP_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // d is registered so it lines up with the SHIFT cycle that owns each bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg <= 1'b0;
            cnt_reg      <= '0;
            frame_reg    <= '0;
            d_reg        <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            d_reg <= 1'b0;
            if (accept) begin
                frame_reg <= frame_in;
                d_reg     <= frame_in[N-1];
            end else if (state_reg == ST_SHIFT && state_next == ST_SHIFT) begin
                d_reg     <= frame_reg[N-2];
                frame_reg <= {frame_reg[N-2:0], 1'b0};
            end
        end
    end

    assign d = d_reg;

`ifdef LVT_HOST_READBACK_EN
    logic [RW-1:0] rd_data_reg;
    logic          rd_valid_reg;

    // first captured bit ends up in the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= (state_reg == ST_CAPTURE) && (cnt_reg == CAP_LAST);
            if (state_reg == ST_CAPTURE) begin
                rd_data_reg <= {rd_data_reg[RW-2:0], q};
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
`else
    logic unused_q;

    assign unused_q = q;
    assign rd_data  = '0;
    assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lvt_serial_host.sv
// Randomized self-checking bench for lvt_serial_host against a cycle-timeline model.
`timescale 1ns/1ps
module tb_lvt_serial_host;

    localparam int W   = 4;
    localparam int DP  = 8;
    localparam int P   = 2;
    localparam int HC  = 2;
    localparam int RL  = 3;
    localparam int AW  = $clog2(DP);
    localparam int AWP = P * AW;
    localparam int N   = P * (AW + W + 1);
    localparam int RW  = P * W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [AWP-1:0] cmd_addr = '0;
    logic [RW-1:0]  cmd_data = '0;
    logic [P-1:0]   cmd_en = '0;
    logic           d;
    logic           push;
    logic           q = 1'b0;
    logic [RW-1:0]  rd_data;
    logic           rd_valid;
    logic           busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // per-cycle signature: {d, push, busy, cmd_ready, rd_valid}
    logic [4:0]    exp_q[$];
    logic [4:0]    obs_q[$];
    logic [RW-1:0] rd_last;
    logic [RW-1:0] rd_at_start;
    bit            timed_out;

    lvt_serial_host #(
        .WIDTH   (W),
        .DEPTH   (DP),
        .PORTS   (P),
        .HOLD_CYC(HC),
        .RD_LAT  (RL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .cmd_en   (cmd_en),
        .d        (d),
        .push     (push),
        .q        (q),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] sig_now();
        return {d, push, busy, cmd_ready, rd_valid};
    endfunction

    function automatic logic [RW-1:0] exp_rd(input logic [RW-1:0] qbits);
`ifdef LVT_HOST_READBACK_EN
        return qbits;
`else
        return '0;
`endif
    endfunction

    // Expected timeline from the first SHIFT cycle to the return to IDLE
    function automatic void build_exp(input logic [N-1:0] f);
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back({f[N-1-k], 4'b0100});
        for (int k = 0; k < HC; k++) exp_q.push_back(5'b00100);
        exp_q.push_back(5'b01100);
`ifdef LVT_HOST_READBACK_EN
        for (int k = 0; k < RL + RW; k++) exp_q.push_back(5'b00100);
        exp_q.push_back(5'b00011);
`else
        exp_q.push_back(5'b00010);
`endif
    endfunction

    // Issues one command and records the observed timeline; ends in the IDLE
    // cycle without advancing, so a following call is back-to-back.
    task automatic run_cmd(input logic [P-1:0] en, input logic [RW-1:0] data,
                           input logic [AWP-1:0] addr, input logic [RW-1:0] qbits);
        int cap0;
        cap0 = N + HC + 1 + RL;
        build_exp({en, data, addr});
        obs_q.delete();
        timed_out = 0;
        for (int t = 0; t < 64 && cmd_ready !== 1'b1; t++) step();
        if (cmd_ready !== 1'b1) begin
            timed_out = 1;
            return;
        end
        cmd_valid = 1'b1;
        cmd_en    = en;
        cmd_data  = data;
        cmd_addr  = addr;
        step();
        rd_at_start = rd_data;
        for (int i = 0; i < exp_q.size(); i++) begin
            obs_q.push_back(sig_now());
            if (i == exp_q.size() - 1) begin
                rd_last   = rd_data;
                cmd_valid = 1'b0;
            end else begin
                if (i >= cap0 && i < cap0 + RW) q = qbits[RW-1-(i-cap0)];
                else q = 1'($urandom);
                cmd_valid = 1'($urandom);
                cmd_en    = P'($urandom);
                cmd_data  = RW'($urandom);
                cmd_addr  = AWP'($urandom);
                step();
            end
        end
        $display("cmd en=%b data=%h addr=%b q=%h -> rd_data=%h cycles=%0d",
                 en, data, addr, qbits, rd_last, obs_q.size());
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_en    = 2'b11;
        cmd_data  = 8'hFF;
        cmd_addr  = 6'h3F;
        step();
        step();
        step();
        chk_cnt++;
        if ({d, push, cmd_ready, busy, rd_valid} !== 5'b0)
            $display("FAIL reset_outputs: got d/push/ready/busy/rd_valid=%b want 00000",
                     {d, push, cmd_ready, busy, rd_valid});
        else pass_cnt++;
        chk_cnt++;
        if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 00", rd_data);
        else pass_cnt++;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk_cnt++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_ready_early: got %b want 0", cmd_ready);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({cmd_ready, busy} !== 2'b10)
            $display("FAIL reset_ready_next: got ready/busy=%b want 10", {cmd_ready, busy});
        else pass_cnt++;
        $display("reset released, cmd_ready=%b", cmd_ready);
    endtask

    task automatic test_frame_a5();
        int push_idx;
        run_cmd(2'b10, 8'hA5, 6'b011101, 8'hC3);
        chk_cnt++;
        if (timed_out) $display("FAIL a5_accept: cmd_ready never rose, want 1");
        else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL a5_cycle%0d: got %b want %b", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
        push_idx = -1;
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i][3] === 1'b1 && push_idx < 0) push_idx = i;
        chk_cnt++;
        if (push_idx != (N - 1) + 3)
            $display("FAIL a5_push_delay: got index %0d want %0d", push_idx, (N - 1) + 3);
        else pass_cnt++;
        chk_cnt++;
        if (rd_last !== exp_rd(8'hC3))
            $display("FAIL a5_rd_data: got %h want %h", rd_last, exp_rd(8'hC3));
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            q = 1'($urandom);
            step();
        end
        chk_cnt++;
        if (rd_data !== exp_rd(8'hC3) || rd_valid !== 1'b0)
            $display("FAIL a5_rd_hold: got rd_data=%h rd_valid=%b want %h 0",
                     rd_data, rd_valid, exp_rd(8'hC3));
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [P-1:0]   en;
        logic [RW-1:0]  data;
        logic [AWP-1:0] addr;
        logic [RW-1:0]  qb;
        for (int n = 0; n < 6; n++) begin
            en   = P'($urandom);
            data = RW'($urandom);
            addr = AWP'($urandom);
            qb   = RW'($urandom);
            run_cmd(en, data, addr, qb);
            chk_cnt++;
            if (timed_out || obs_q.size() != exp_q.size() || obs_q != exp_q)
                $display("FAIL rand%0d_timeline: got %0d cycles (timeout=%0b) want %0d matching cycles",
                         n, obs_q.size(), timed_out, exp_q.size());
            else pass_cnt++;
            chk_cnt++;
            if (rd_last !== exp_rd(qb))
                $display("FAIL rand%0d_rd_data: got %h want %h", n, rd_last, exp_rd(qb));
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] qa;
        logic [RW-1:0] qb;
        qa = RW'($urandom);
        qb = ~qa;
        run_cmd(2'b01, 8'h3C, 6'b100110, qa);
        chk_cnt++;
        if (timed_out || obs_q != exp_q)
            $display("FAIL b2b_first_timeline: got %0d cycles want %0d matching", obs_q.size(), exp_q.size());
        else pass_cnt++;
        run_cmd(2'b11, 8'h96, 6'b010001, qb);
        chk_cnt++;
        if (timed_out || obs_q != exp_q)
            $display("FAIL b2b_second_timeline: got %0d cycles want %0d matching", obs_q.size(), exp_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (rd_at_start !== exp_rd(qa))
            $display("FAIL b2b_rd_kept: got %h want %h", rd_at_start, exp_rd(qa));
        else pass_cnt++;
        chk_cnt++;
        if (rd_last !== exp_rd(qb))
            $display("FAIL b2b_rd_data: got %h want %h", rd_last, exp_rd(qb));
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_abort();
        bit stray;
        for (int t = 0; t < 64 && cmd_ready !== 1'b1; t++) step();
        cmd_valid = 1'b1;
        cmd_en    = 2'b11;
        cmd_data  = 8'hFF;
        cmd_addr  = 6'h3F;
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk_cnt++;
        if ({d, busy} !== 2'b11) $display("FAIL abort_pre_bit6: got d/busy=%b want 11", {d, busy});
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({d, busy, push, cmd_ready} !== 4'b0)
            $display("FAIL abort_async: got d/busy/push/ready=%b want 0000", {d, busy, push, cmd_ready});
        else pass_cnt++;
        chk_cnt++;
        if (rd_data !== '0) $display("FAIL abort_rd_clear: got %h want 00", rd_data);
        else pass_cnt++;
        step();
        step();
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (push === 1'b1 || rd_valid === 1'b1 || busy === 1'b1) stray = 1;
        end
        chk_cnt++;
        if (stray) $display("FAIL abort_no_push: got activity after abort want none");
        else pass_cnt++;
        $display("abort at bit 6, idle check stray=%0b", stray);
        run_cmd(2'b10, 8'hA5, 6'b011101, 8'h5A);
        chk_cnt++;
        if (timed_out || obs_q != exp_q)
            $display("FAIL abort_restart_timeline: got first d=%b cycles=%0d want d=1 cycles=%0d",
                     (obs_q.size() > 0) ? obs_q[0][4] : 1'bx, obs_q.size(), exp_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (rd_last !== exp_rd(8'h5A))
            $display("FAIL abort_restart_rd: got %h want %h", rd_last, exp_rd(8'h5A));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
